// File: rtl/riscv_aes_pkg.sv
// Shared types and constants for the AES result write-back path.
package riscv_aes_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned AES_BEATS = 4;

  typedef struct packed {
    logic [31:0]          addr;
    logic [AES_BLK_W-1:0] data;
  } aes_wb_entry_t;

  typedef enum logic [0:0] {IDLE, WRITE} aes_wb_state_e;

  // Word idx of a block, most-significant word first.
  function automatic logic [31:0] aes_word(input logic [AES_BLK_W-1:0] blk, input logic [1:0] idx);
    logic [1:0] rev;
    rev = 2'd3 - idx;
    return blk[{rev, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/riscv_aes_wb_fifo.sv
// DEPTH-entry synchronous FIFO of AES result entries; exposes the head and the entry behind it.
module riscv_aes_wb_fifo
  import riscv_aes_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  aes_wb_entry_t                wdata,
  input  logic                         pop,
  output aes_wb_entry_t                rdata,
  output aes_wb_entry_t                rdata_next,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  aes_wb_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rdata      = mem_q[rd_ptr_q];
  assign rdata_next = mem_q[rd_ptr_q + AW'(1)];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/riscv_aes_wb_buffer.sv
// Captures AES cipher results and drains each as four 32-bit OBI writes,
// issuing credit so in-flight blocks can never overflow the buffer.
module riscv_aes_wb_buffer
  import riscv_aes_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PIPE_DEPTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_aes_in,
  input  logic                 start_aes_out,
  input  logic [AES_BLK_W-1:0] dataout,
  input  logic [31:0]          addrout,
  output logic                 ready_o,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  output logic [31:0]          data_addr_o,
  output logic                 data_we_o,
  output logic [3:0]           data_be_o,
  output logic [31:0]          data_wdata_o,
  output logic                 blk_done_o,
  output logic                 busy_o,
  output logic                 overflow_o
);

  localparam int unsigned IW = $clog2(PIPE_DEPTH+1);
  localparam int unsigned CW = $clog2(DEPTH+1);

  aes_wb_state_e state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic [IW-1:0] inflight_q, inflight_d;

  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;

  aes_wb_entry_t push_entry, head, head_next, src;
  logic          fifo_full, fifo_empty, push_ok, last_grant;
  logic [CW-1:0] fifo_count, count_next;
  logic [31:0]   credit_sum;

  assign push_entry = '{addr: {addrout[31:2], 2'b00}, data: dataout};
  assign push_ok    = start_aes_out && !fifo_full;
  assign last_grant = (state_q == WRITE) && data_gnt_i && (beat_q == 2'(AES_BEATS-1));
  assign count_next = fifo_count + CW'(push_ok) - CW'(last_grant);

  riscv_aes_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (start_aes_out),
    .wdata      (push_entry),
    .pop        (last_grant),
    .rdata      (head),
    .rdata_next (head_next),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // In-flight blocks inside the cipher, saturating at both ends.
  always_comb begin
    inflight_d = inflight_q;
    if (start_aes_in && !start_aes_out && (inflight_q != IW'(PIPE_DEPTH))) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!start_aes_in && start_aes_out && (inflight_q != '0)) begin
      inflight_d = inflight_q - IW'(1);
    end
  end

  assign credit_sum = 32'(fifo_count) + 32'(inflight_q);
  assign ready_o    = (credit_sum < DEPTH);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = WRITE;
          beat_d  = '0;
        end
      end
      WRITE: begin
        if (data_gnt_i) begin
          if (!last_grant) begin
            beat_d = beat_q + 2'd1;
          end else begin
            beat_d = '0;
            if (count_next == '0) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; after a pop the next head is
  // either the entry behind the current one or the result being captured.
  always_comb begin
    src = head;
    if (last_grant) src = (fifo_count > CW'(1)) ? head_next : push_entry;
    req_d   = (state_d == WRITE);
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_d == WRITE) begin
      addr_d  = src.addr + {28'b0, beat_d, 2'b00};
      wdata_d = aes_word(src.data, beat_d);
    end
    done_d = last_grant;
    busy_d = (count_next != '0) || (state_d == WRITE) || (inflight_d != '0);
    ovf_d  = ovf_q || (start_aes_out && fifo_full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_req_o   = req_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;
  assign data_we_o    = req_q;
  assign data_be_o    = 4'hF;
  assign blk_done_o   = done_q;
  assign busy_o       = busy_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_riscv_aes_wb_buffer.sv
// Self-checking bench for riscv_aes_wb_buffer against a queue-of-beats reference model.
module tb_riscv_aes_wb_buffer;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned PIPE_DEPTH = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_aes_in = 1'b0;
  logic         start_aes_out = 1'b0;
  logic [127:0] dataout = '0;
  logic [31:0]  addrout = '0;
  logic         ready_o;
  logic         data_req_o;
  logic         data_gnt_i = 1'b0;
  logic [31:0]  data_addr_o;
  logic         data_we_o;
  logic [3:0]   data_be_o;
  logic [31:0]  data_wdata_o;
  logic         blk_done_o;
  logic         busy_o;
  logic         overflow_o;

  always #5 clk = ~clk;

  riscv_aes_wb_buffer #(
    .DEPTH      (DEPTH),
    .PIPE_DEPTH (PIPE_DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_aes_in  (start_aes_in),
    .start_aes_out (start_aes_out),
    .dataout       (dataout),
    .addrout       (addrout),
    .ready_o       (ready_o),
    .data_req_o    (data_req_o),
    .data_gnt_i    (data_gnt_i),
    .data_addr_o   (data_addr_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_wdata_o  (data_wdata_o),
    .blk_done_o    (blk_done_o),
    .busy_o        (busy_o),
    .overflow_o    (overflow_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending write beats {addr, word}, in-flight count, flags.
  logic [63:0] exp_q[$];
  int  m_inflight = 0;
  bit  m_ovf = 0, m_done = 0, m_req = 0;
  int  m_grants = 0;
  int  dut_grants = 0;

  function automatic int m_blocks();
    return (exp_q.size() + 3) / 4;
  endfunction

  function automatic bit m_ready();
    return (m_blocks() + m_inflight) < int'(DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: check outputs, drive inputs, advance model to the next edge.
  task automatic step(input bit s_in, input bit s_out, input logic [127:0] d,
                      input logic [31:0] a, input bit g);
    int nb_before;
    logic [31:0] base;
    chk("ready", 64'(ready_o), 64'(m_ready()));
    chk("req", 64'(data_req_o), 64'(m_req));
    chk("blk_done", 64'(blk_done_o), 64'(m_done));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
    chk("busy", 64'(busy_o), 64'(m_blocks() > 0 || m_inflight > 0));
    if (m_req) begin
      chk("beat", {data_addr_o, data_wdata_o}, exp_q[0]);
      chk("we_be", 64'({data_we_o, data_be_o}), 64'h1F);
    end
    if (data_req_o && g) dut_grants++;
    start_aes_in  = s_in;
    start_aes_out = s_out;
    dataout       = d;
    addrout       = a;
    data_gnt_i    = g;
    nb_before = m_blocks();
    m_done = 0;
    if (m_req && g) begin
      void'(exp_q.pop_front());
      m_grants++;
      if (m_grants % 4 == 0) m_done = 1;
    end
    if (s_out) begin
      if (nb_before < int'(DEPTH)) begin
        base = a & 32'hFFFF_FFFC;
        for (int i = 0; i < 4; i++) exp_q.push_back({base + 32'(4 * i), d[127 - 32 * i -: 32]});
      end else begin
        m_ovf = 1;
      end
    end
    if (s_in && !s_out && m_inflight < int'(PIPE_DEPTH)) m_inflight++;
    else if (!s_in && s_out && m_inflight > 0) m_inflight--;
    m_req = (nb_before > 0) && (m_blocks() > 0);
    @(negedge clk);
  endtask

  task automatic drain(input int gnt_pct, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || m_done) && n < budget) begin
      step(0, 0, '0, '0, $urandom_range(99) < gnt_pct);
      n++;
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
    step(0, 0, '0, '0, 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", 64'(data_req_o), 64'd0);
    chk("rst_done_ovf", 64'({blk_done_o, overflow_o, busy_o}), 64'd0);
    chk("rst_addr_wdata", {data_addr_o, data_wdata_o}, 64'd0);
    start_aes_in = 0; start_aes_out = 0; data_gnt_i = 0;
    exp_q.delete();
    m_inflight = 0; m_ovf = 0; m_done = 0; m_req = 0; m_grants = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base_g, n;
    logic [127:0] rd;
    repeat (2) @(negedge clk);
    chk("init_req", 64'(data_req_o), 64'd0);
    chk("init_flags", 64'({blk_done_o, overflow_o, busy_o}), 64'd0);
    chk("init_addr_wdata", {data_addr_o, data_wdata_o}, 64'd0);
    chk("init_ready", 64'(ready_o), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single block, grant always high
    base_g = dut_grants;
    step(0, 1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 32'h1000_0000, 1);
    drain(100, 20);
    chk("single_writes", 64'(dut_grants - base_g), 64'd4);

    // 2: grant stall on beat 1
    step(0, 1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 32'h1000_0000, 0);
    n = 0;
    while (!m_req && n < 5) begin step(0, 0, '0, '0, 0); n++; end
    step(0, 0, '0, '0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", 64'(data_addr_o), 64'h1000_0004);
      chk("stall_wdata", 64'(data_wdata_o), 64'h4455_6677);
      step(0, 0, '0, '0, 0);
    end
    drain(100, 20);

    // 3: credit with four blocks in flight, then a simultaneous issue/return
    for (int i = 0; i < 4; i++) begin
      chk("credit_pre", 64'(ready_o), 64'd1);
      step(1, 0, '0, '0, 0);
    end
    chk("credit_full", 64'(ready_o), 64'd0);
    step(0, 1, {4{$urandom}}, $urandom, 1);
    drain(100, 20);
    step(1, 1, {4{$urandom}}, $urandom, 1);
    drain(100, 20);
    while (m_inflight > 0) step(0, 1, {4{$urandom}}, $urandom, 1);
    drain(100, 40);

    // 4: overflow with grant held low
    base_g = dut_grants;
    for (int i = 0; i < 5; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      step(0, 1, rd, $urandom, 0);
    end
    step(0, 0, '0, '0, 0);
    chk("ovf_sticky", 64'(overflow_o), 64'd1);
    drain(100, 40);
    chk("ovf_writes", 64'(dut_grants - base_g), 64'd16);
    chk("ovf_still", 64'(overflow_o), 64'd1);

    // 5: address alignment and wrap
    step(0, 1, {$urandom, $urandom, $urandom, $urandom}, 32'hFFFF_FFF6, 1);
    drain(70, 60);

    // 6: reset during beat 2
    step(0, 1, {$urandom, $urandom, $urandom, $urandom}, 32'h2000_0040, 1);
    step(0, 1, {$urandom, $urandom, $urandom, $urandom}, 32'h3000_0000, 1);
    n = 0;
    while (!(m_req && m_grants % 4 == 2) && n < 10) begin step(0, 0, '0, '0, 1); n++; end
    do_reset();
    chk("post_rst_ready", 64'(ready_o), 64'd1);
    step(0, 0, '0, '0, 1);
    step(0, 0, '0, '0, 0);

    // Random traffic honouring credit
    for (int i = 0; i < 400; i++) begin
      step(m_ready() && ($urandom_range(1) == 1), (m_inflight > 0) && ($urandom_range(2) == 0),
           {$urandom, $urandom, $urandom, $urandom}, $urandom, $urandom_range(3) != 0);
    end
    n = 0;
    while (m_inflight > 0 && n < 20) begin
      step(0, 1, {$urandom, $urandom, $urandom, $urandom}, $urandom, $urandom_range(1) == 1);
      n++;
    end
    drain(60, 200);
    chk("rand_no_ovf", 64'(overflow_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
